// File: rtl/png_chunk_parser_pkg.sv
// Shared constants for the PNG chunk parser: signature, chunk types, error codes, FSM states.
package png_chunk_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIG,
        ST_LEN,
        ST_TYP,
        ST_DAT,
        ST_CRC,
        ST_ERR
    } state_t;

    localparam logic [63:0] PNG_SIG  = 64'h8950_4E47_0D0A_1A0A;
    localparam logic [31:0] TYP_IHDR = 32'h4948_4452;
    localparam logic [31:0] TYP_IDAT = 32'h4944_4154;
    localparam logic [31:0] TYP_IEND = 32'h4945_4E44;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SIG  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_CRC  = 2'd3;

    // Signature byte idx, 0 being the first byte in file order.
    function automatic logic [7:0] sig_byte(input logic [2:0] idx);
        logic [5:0] base;
        base = {3'd7 - idx, 3'b000};
        return PNG_SIG[base +: 8];
    endfunction

endpackage

// File: rtl/png_chunk_parser_crc32_byte.sv
// Combinational single-byte update of the reflected CRC-32 (poly 0xEDB88320).
module png_crc32_byte (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/png_chunk_parser.sv
// PNG byte-stream chunk parser: signature, length/type headers, payload forwarding, CRC check.
// Macro PNG_CHUNK_PARSER_CRC_CHK_EN enables CRC checking; without it CRC bytes are skipped and reported ok.
module png_chunk_parser
    import png_chunk_parser_pkg::*;
#(
    parameter logic [31:0] LEN_MAX = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic        val_i,
    input  logic [7:0]  dat_i,
    output logic        hdr_val_o,
    output logic [31:0] hdr_len_o,
    output logic [31:0] hdr_typ_o,
    output logic        val_o,
    output logic [7:0]  dat_o,
    output logic        lst_o,
    output logic        crc_val_o,
    output logic        crc_ok_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    state_t      state;
    logic [2:0]  sig_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] rem;
    logic [31:0] len_sr;
    logic [31:0] typ_sr;
    logic [31:0] len_next;
    logic [31:0] typ_next;
    logic        crc_match;

    assign len_next = {len_sr[23:0], dat_i};
    assign typ_next = {typ_sr[23:0], dat_i};

`ifdef PNG_CHUNK_PARSER_CRC_CHK_EN
    logic [31:0] crc_q;
    logic [31:0] crc_upd;
    logic [31:0] crc_rx;

    png_crc32_byte u_crc (
        .crc_in (crc_q),
        .data   (dat_i),
        .crc_out(crc_upd)
    );

    assign crc_match = ({crc_rx[23:0], dat_i} == ~crc_q);

    // The running CRC covers type and payload bytes; it restarts when the next chunk's length begins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q  <= CRC_INIT;
            crc_rx <= 32'd0;
        end else if (start_i) begin
            crc_q  <= CRC_INIT;
        end else if (val_i) begin
            if (state == ST_TYP || state == ST_DAT)
                crc_q <= crc_upd;
            else if (state == ST_CRC && byte_cnt == 2'd3)
                crc_q <= CRC_INIT;
            if (state == ST_CRC)
                crc_rx <= {crc_rx[23:0], dat_i};
        end
    end
`else
    assign crc_match = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            sig_cnt    <= 3'd0;
            byte_cnt   <= 2'd0;
            rem        <= 32'd0;
            len_sr     <= 32'd0;
            typ_sr     <= 32'd0;
            hdr_val_o  <= 1'b0;
            hdr_len_o  <= 32'd0;
            hdr_typ_o  <= 32'd0;
            val_o      <= 1'b0;
            dat_o      <= 8'd0;
            lst_o      <= 1'b0;
            crc_val_o  <= 1'b0;
            crc_ok_o   <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end else begin
            hdr_val_o <= 1'b0;
            val_o     <= 1'b0;
            lst_o     <= 1'b0;
            crc_val_o <= 1'b0;
            crc_ok_o  <= 1'b0;
            done_o    <= 1'b0;
            if (start_i) begin
                state      <= ST_SIG;
                sig_cnt    <= 3'd0;
                byte_cnt   <= 2'd0;
                rem        <= 32'd0;
                err_o      <= 1'b0;
                err_code_o <= ERR_NONE;
            end else if (val_i) begin
                case (state)
                    ST_SIG: begin
                        if (dat_i != sig_byte(sig_cnt)) begin
                            state      <= ST_ERR;
                            err_o      <= 1'b1;
                            err_code_o <= ERR_SIG;
                        end else if (sig_cnt == 3'd7) begin
                            state   <= ST_LEN;
                            sig_cnt <= 3'd0;
                        end else begin
                            sig_cnt <= sig_cnt + 3'd1;
                        end
                    end
                    ST_LEN: begin
                        len_sr   <= len_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (len_next > LEN_MAX) begin
                                state      <= ST_ERR;
                                err_o      <= 1'b1;
                                err_code_o <= ERR_LEN;
                            end else begin
                                state <= ST_TYP;
                            end
                        end
                    end
                    ST_TYP: begin
                        typ_sr   <= typ_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            hdr_val_o <= 1'b1;
                            hdr_len_o <= len_sr;
                            hdr_typ_o <= typ_next;
                            rem       <= len_sr;
                            state     <= (len_sr != 32'd0) ? ST_DAT : ST_CRC;
                        end
                    end
                    ST_DAT: begin
                        val_o <= 1'b1;
                        dat_o <= dat_i;
                        rem   <= rem - 32'd1;
                        if (rem == 32'd1) begin
                            lst_o <= 1'b1;
                            state <= ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            crc_val_o <= 1'b1;
                            crc_ok_o  <= crc_match;
                            if (!crc_match) begin
                                state      <= ST_ERR;
                                err_o      <= 1'b1;
                                err_code_o <= ERR_CRC;
                            end else if (typ_sr == TYP_IEND) begin
                                done_o <= 1'b1;
                                state  <= ST_IDLE;
                            end else begin
                                state <= ST_LEN;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_png_chunk_parser.sv
// Scoreboard bench for png_chunk_parser: a stream-level reference model predicts output events.
module tb_png_chunk_parser;

    localparam logic [31:0] LEN_MAX  = 32'h7FFF_FFFF;
    localparam logic [63:0] SIG      = 64'h8950_4E47_0D0A_1A0A;
    localparam logic [31:0] T_IHDR   = 32'h4948_4452;
    localparam logic [31:0] T_IDAT   = 32'h4944_4154;
    localparam logic [31:0] T_IEND   = 32'h4945_4E44;

    localparam logic [2:0] EV_HDR  = 3'd0;
    localparam logic [2:0] EV_PAY  = 3'd1;
    localparam logic [2:0] EV_CRC  = 3'd2;
    localparam logic [2:0] EV_DONE = 3'd3;
    localparam logic [2:0] EV_ERR  = 3'd4;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i;
    logic        val_i;
    logic [7:0]  dat_i;
    logic        hdr_val_o;
    logic [31:0] hdr_len_o;
    logic [31:0] hdr_typ_o;
    logic        val_o;
    logic [7:0]  dat_o;
    logic        lst_o;
    logic        crc_val_o;
    logic        crc_ok_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int          total = 0;
    int          bad = 0;
    ev_t         expq[$];
    bq_t         stim;
    bq_t         pay;
    logic [31:0] last_len = 32'd0;
    logic [31:0] last_typ = 32'd0;
    logic        prev_err = 1'b0;

    png_chunk_parser #(.LEN_MAX(LEN_MAX)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .val_i     (val_i),
        .dat_i     (dat_i),
        .hdr_val_o (hdr_val_o),
        .hdr_len_o (hdr_len_o),
        .hdr_typ_o (hdr_typ_o),
        .val_o     (val_o),
        .dat_o     (dat_o),
        .lst_o     (lst_o),
        .crc_val_o (crc_val_o),
        .crc_ok_o  (crc_ok_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] sigb(input int k);
        return SIG[63 - 8*k -: 8];
    endfunction

    task automatic push_ev(input logic [2:0] kind, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = kind;
        e.a = a;
        e.b = b;
        expq.push_back(e);
    endtask

    // Reference: walk the byte stream as a file, producing the event sequence the parser must emit.
    task automatic model(input bq_t s, output logic [1:0] code);
        int          i;
        logic [31:0] len, typ, rx, c;
        logic        ok;
        i = 0;
        code = 2'd0;
        for (int k = 0; k < 8; k++) begin
            if (i >= s.size()) return;
            if (s[i] != sigb(k)) begin
                push_ev(EV_ERR, 32'd1, 32'd0);
                code = 2'd1;
                return;
            end
            i++;
        end
        forever begin
            if (i + 4 > s.size()) return;
            len = {s[i], s[i+1], s[i+2], s[i+3]};
            i += 4;
            if (len > LEN_MAX) begin
                push_ev(EV_ERR, 32'd2, 32'd0);
                code = 2'd2;
                return;
            end
            if (i + 4 > s.size()) return;
            typ = {s[i], s[i+1], s[i+2], s[i+3]};
            c = 32'hFFFF_FFFF;
            for (int k = 0; k < 4; k++) c = crc_step(c, s[i+k]);
            i += 4;
            push_ev(EV_HDR, len, typ);
            last_len = len;
            last_typ = typ;
            for (longint p = 0; p < longint'(len); p++) begin
                if (i >= s.size()) return;
                push_ev(EV_PAY, {24'd0, s[i]}, {31'd0, p == longint'(len) - 1});
                c = crc_step(c, s[i]);
                i++;
            end
            if (i + 4 > s.size()) return;
            rx = {s[i], s[i+1], s[i+2], s[i+3]};
            i += 4;
`ifdef PNG_CHUNK_PARSER_CRC_CHK_EN
            ok = (rx == ~c);
`else
            ok = 1'b1;
`endif
            push_ev(EV_CRC, {31'd0, ok}, 32'd0);
            if (!ok) begin
                push_ev(EV_ERR, 32'd3, 32'd0);
                code = 2'd3;
                return;
            end
            if (typ == T_IEND) begin
                push_ev(EV_DONE, 32'd0, 32'd0);
                return;
            end
        end
    endtask

    task automatic add_sig();
        for (int k = 0; k < 8; k++) stim.push_back(sigb(k));
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) stim.push_back(w[8*k +: 8]);
    endtask

    // Appends a chunk carrying the current pay queue; bad flips one CRC bit.
    task automatic add_chunk(input logic [31:0] typ, input bit bad_crc);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        add_word(pay.size());
        add_word(typ);
        for (int k = 3; k >= 0; k--) c = crc_step(c, typ[8*k +: 8]);
        foreach (pay[k]) begin
            stim.push_back(pay[k]);
            c = crc_step(c, pay[k]);
        end
        add_word(~c ^ {31'd0, bad_crc});
    endtask

    task automatic rand_pay(input int n);
        pay.delete();
        for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        val_i   = 1'($urandom);
        dat_i   = 8'($urandom);
        tick();
        start_i = 1'b0;
        val_i   = 1'b0;
    endtask

    // gap: 0 back-to-back, 1 random idle cycles, 2 one idle cycle before every byte
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = (gap == 2) ? 1 : (gap == 1) ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0) : 0;
        repeat (n) begin
            val_i = 1'b0;
            dat_i = 8'($urandom);
            tick();
        end
        val_i = 1'b1;
        dat_i = b;
        tick();
        val_i = 1'b0;
    endtask

    task automatic run(input int gap, input string tag, input bit chk_sig_err);
        logic [1:0] code;
        model(stim, code);
        do_start();
        foreach (stim[k]) begin
            send_byte(stim[k], gap);
            if (chk_sig_err && k == 0) begin
                check({tag, "_err_1cyc"}, {29'd0, err_o, err_code_o}, 32'd5);
            end
        end
        repeat (4) tick();
        check({tag, "_leftover"}, expq.size(), 32'd0);
        check({tag, "_err_code"}, {30'd0, err_code_o}, {30'd0, code});
        check({tag, "_err"}, {31'd0, err_o}, {31'd0, code != 2'd0});
        check({tag, "_hdr_len"}, hdr_len_o, last_len);
        check({tag, "_hdr_typ"}, hdr_typ_o, last_typ);
        expq.delete();
    endtask

    task automatic expect_ev(input logic [2:0] kind, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event actual_kind=%0d a=%h b=%h required=none", kind, a, b);
        end else begin
            e = expq.pop_front();
            check("event_kind", {29'd0, kind}, {29'd0, e.kind});
            check("event_a", a, e.a);
            check("event_b", b, e.b);
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            prev_err = 1'b0;
        end else begin
            if (hdr_val_o) expect_ev(EV_HDR, hdr_len_o, hdr_typ_o);
            if (val_o) expect_ev(EV_PAY, {24'd0, dat_o}, {31'd0, lst_o});
            if (crc_val_o) expect_ev(EV_CRC, {31'd0, crc_ok_o}, 32'd0);
            if (done_o) expect_ev(EV_DONE, 32'd0, 32'd0);
            if (err_o && !prev_err) expect_ev(EV_ERR, {30'd0, err_code_o}, 32'd0);
            prev_err = err_o;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pulses"}, {26'd0, hdr_val_o, val_o, lst_o, crc_val_o, done_o, err_o}, 32'd0);
        check({tag, "_hdr_len"}, hdr_len_o, 32'd0);
        check({tag, "_hdr_typ"}, hdr_typ_o, 32'd0);
        check({tag, "_code_dat"}, {22'd0, err_code_o, dat_o}, 32'd0);
    endtask

    initial begin
        rstn    = 1'b0;
        start_i = 1'b0;
        val_i   = 1'b0;
        dat_i   = 8'd0;
        repeat (2) tick();
        check_idle_outputs("reset");
        rstn = 1'b1;
        repeat (2) tick();

        // Minimal file: signature then IEND, followed by junk the idle parser must ignore.
        stim.delete();
        add_sig();
        add_word(32'd0);
        add_word(T_IEND);
        add_word(32'hAE42_6082);
        for (int k = 0; k < 6; k++) stim.push_back(8'($urandom));
        run(0, "iend", 1'b0);

        stim.delete();
        add_sig();
        add_word(32'd0);
        add_word(T_IEND);
        add_word(32'hAE42_6083);
        run(1, "iend_badcrc", 1'b0);

        stim.delete();
        stim.push_back(8'h88);
        for (int k = 0; k < 12; k++) stim.push_back(8'($urandom));
        run(0, "sig_err", 1'b1);

        stim.delete();
        add_sig();
        add_word(32'h8000_0000);
        add_word(T_IDAT);
        for (int k = 0; k < 6; k++) stim.push_back(8'($urandom));
        run(1, "len_err", 1'b0);

        stim.delete();
        add_sig();
        pay.delete();
        pay.push_back(8'h01);
        pay.push_back(8'h02);
        pay.push_back(8'h03);
        add_chunk(T_IDAT, 1'b0);
        pay.delete();
        add_chunk(T_IEND, 1'b0);
        run(2, "idat3_toggle", 1'b0);

        // Abandon a chunk mid-payload with reset, then parse a clean file.
        stim.delete();
        add_sig();
        rand_pay(10);
        add_chunk(T_IDAT, 1'b0);
        stim = stim[0:19];
        begin
            logic [1:0] code;
            model(stim, code);
        end
        do_start();
        foreach (stim[k]) send_byte(stim[k], 0);
        repeat (2) tick();
        rstn = 1'b0;
        last_len = 32'd0;
        last_typ = 32'd0;
        tick();
        check_idle_outputs("mid_rst");
        check("mid_rst_leftover", expq.size(), 32'd0);
        expq.delete();
        rstn = 1'b1;
        tick();
        stim.delete();
        add_sig();
        pay.delete();
        add_chunk(T_IEND, 1'b0);
        run(1, "post_rst", 1'b0);

        // Random files: IHDR, a few IDAT chunks (possibly empty), IEND, occasional corruption.
        for (int it = 0; it < 8; it++) begin
            int nd;
            stim.delete();
            add_sig();
            if ($urandom_range(0, 7) == 0) stim[$urandom_range(0, 7)] ^= 8'h10;
            rand_pay(13);
            add_chunk(T_IHDR, 1'b0);
            nd = $urandom_range(0, 3);
            for (int c = 0; c < nd; c++) begin
                rand_pay($urandom_range(0, 12));
                add_chunk(T_IDAT, $urandom_range(0, 5) == 0);
            end
            pay.delete();
            add_chunk(T_IEND, $urandom_range(0, 5) == 0);
            run(it % 3, $sformatf("rand%0d", it), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
